// File: rtl/pipeline_ex_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ex_if
// Brief    : Issue-side and result-side bundle of the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_ex_if;
  logic [31:0] pc_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] imm_i;
  logic [5:0]  opcode_i;
  logic        funct7b_i;
  logic [4:0]  rd_i;
  logic        stall_i;
  logic [31:0] alu_out_o;
  logic [31:0] dmem_data_o;
  logic [5:0]  opcode_o;
  logic [4:0]  rd_o;
  logic        stall_o;
  logic        busy_o;

  // Upstream decode stage drives the instruction and watches busy_o.
  modport master (
    output pc_i, rs1_data_i, rs2_data_i, imm_i, opcode_i, funct7b_i, rd_i, stall_i,
    input  alu_out_o, dmem_data_o, opcode_o, rd_o, stall_o, busy_o
  );

  modport slave (
    input  pc_i, rs1_data_i, rs2_data_i, imm_i, opcode_i, funct7b_i, rd_i, stall_i,
    output alu_out_o, dmem_data_o, opcode_o, rd_o, stall_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_ex.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ex
// Brief    : Execute stage; define SERIAL_SHIFT_EN to replace the barrel
//            shifter with a one-bit-per-cycle shift sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ex (
  input  wire logic     clk,
  input  wire logic     reset,
  pipeline_ex_if.slave  bus
);

  localparam logic [2:0] c_CLS_LOAD  = 3'b000;
  localparam logic [2:0] c_CLS_STORE = 3'b001;
  localparam logic [2:0] c_CLS_OP    = 3'b010;
  localparam logic [2:0] c_CLS_OPIMM = 3'b011;
  localparam logic [2:0] c_CLS_LUI   = 3'b100;
  localparam logic [2:0] c_CLS_AUIPC = 3'b101;
  localparam logic [2:0] c_CLS_JUMP  = 3'b110;

  logic [2:0]  w_cls;
  logic [2:0]  w_f3;
  logic [31:0] w_op_b;
  logic [4:0]  w_shamt;
  logic        w_is_shift;
  logic [31:0] w_sll;
  logic [31:0] w_sr;
  logic [31:0] w_result;

  logic [31:0] r_alu_out;
  logic [31:0] r_dmem_data;
  logic [5:0]  r_opcode;
  logic [4:0]  r_rd;
  logic        r_stall;

  assign w_cls      = bus.opcode_i[5:3];
  assign w_f3       = bus.opcode_i[2:0];
  assign w_op_b     = (w_cls == c_CLS_OP) ? bus.rs2_data_i : bus.imm_i;
  assign w_shamt    = w_op_b[4:0];
  assign w_is_shift = ((w_cls == c_CLS_OP) || (w_cls == c_CLS_OPIMM)) &&
                      ((w_f3 == 3'b001) || (w_f3 == 3'b101));

`ifdef SERIAL_SHIFT_EN
  // Nonzero shifts are produced by the sequencer; here only shamt 0 remains.
  assign w_sll = bus.rs1_data_i;
  assign w_sr  = bus.rs1_data_i;
`else
  assign w_sll = bus.rs1_data_i << w_shamt;
  assign w_sr  = bus.funct7b_i ? 32'($signed(bus.rs1_data_i) >>> w_shamt)
                               : (bus.rs1_data_i >> w_shamt);
`endif

  always_comb begin
    w_result = 32'd0;
    case (w_cls)
      c_CLS_LOAD, c_CLS_STORE: w_result = bus.rs1_data_i + bus.imm_i;
      c_CLS_OP, c_CLS_OPIMM: begin
        case (w_f3)
          3'b000: w_result = ((w_cls == c_CLS_OP) && bus.funct7b_i) ?
                             (bus.rs1_data_i - w_op_b) : (bus.rs1_data_i + w_op_b);
          3'b001: w_result = w_sll;
          3'b010: w_result = {31'd0, $signed(bus.rs1_data_i) < $signed(w_op_b)};
          3'b011: w_result = {31'd0, bus.rs1_data_i < w_op_b};
          3'b100: w_result = bus.rs1_data_i ^ w_op_b;
          3'b101: w_result = w_sr;
          3'b110: w_result = bus.rs1_data_i | w_op_b;
          default: w_result = bus.rs1_data_i & w_op_b;
        endcase
      end
      c_CLS_LUI:   w_result = bus.imm_i;
      c_CLS_AUIPC: w_result = bus.pc_i + bus.imm_i;
      c_CLS_JUMP:  w_result = bus.pc_i + 32'd4;
      default:     w_result = 32'd0;
    endcase
  end

`ifdef SERIAL_SHIFT_EN
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_shreg;
  logic        w_start;
  logic [31:0] w_step;

  assign w_start = (r_state == S_IDLE) && w_is_shift && (w_shamt != 5'd0) &&
                   !bus.stall_i && !reset;

  // Upstream holds the instruction while busy, so the live opcode picks the direction.
  always_comb begin
    w_step = {r_shreg[30:0], 1'b0};
    if (w_f3 == 3'b101)
      w_step = {bus.funct7b_i & r_shreg[31], r_shreg[31:1]};
  end

  assign bus.busy_o = w_start || ((r_state == S_SHIFT) && (r_cnt != 5'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 5'd0;
      r_shreg     <= 32'd0;
      r_alu_out   <= 32'd0;
      r_dmem_data <= 32'd0;
      r_opcode    <= 6'd0;
      r_rd        <= 5'd0;
      r_stall     <= 1'b0;
    end else begin
      r_alu_out   <= 32'd0;
      r_dmem_data <= 32'd0;
      r_opcode    <= 6'd0;
      r_rd        <= 5'd0;
      r_stall     <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_shreg <= bus.rs1_data_i;
            r_cnt   <= w_shamt;
            r_state <= S_SHIFT;
          end else if (!bus.stall_i) begin
            r_alu_out   <= w_result;
            r_dmem_data <= bus.rs2_data_i;
            r_opcode    <= bus.opcode_i;
            r_rd        <= bus.rd_i;
            r_stall     <= 1'b0;
          end
        end
        default: begin
          r_shreg <= w_step;
          r_cnt   <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_alu_out   <= w_step;
            r_dmem_data <= bus.rs2_data_i;
            r_opcode    <= bus.opcode_i;
            r_rd        <= bus.rd_i;
            r_stall     <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end
`else
  logic w_unused;
  assign w_unused   = w_is_shift;
  assign bus.busy_o = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_out   <= 32'd0;
      r_dmem_data <= 32'd0;
      r_opcode    <= 6'd0;
      r_rd        <= 5'd0;
      r_stall     <= 1'b0;
    end else if (bus.stall_i) begin
      r_alu_out   <= 32'd0;
      r_dmem_data <= 32'd0;
      r_opcode    <= 6'd0;
      r_rd        <= 5'd0;
      r_stall     <= 1'b1;
    end else begin
      r_alu_out   <= w_result;
      r_dmem_data <= bus.rs2_data_i;
      r_opcode    <= bus.opcode_i;
      r_rd        <= bus.rd_i;
      r_stall     <= 1'b0;
    end
  end
`endif

  assign bus.alu_out_o   = r_alu_out;
  assign bus.dmem_data_o = r_dmem_data;
  assign bus.opcode_o    = r_opcode;
  assign bus.rd_o        = r_rd;
  assign bus.stall_o     = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ex.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ex
// Brief    : Self-checking bench for pipeline_ex against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ex;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipeline_ex_if bus ();
  pipeline_ex dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef SERIAL_SHIFT_EN
  localparam bit SERIAL = 1'b1;
`else
  localparam bit SERIAL = 1'b0;
`endif

  typedef struct {
    logic [31:0] alu;
    logic [31:0] dmem;
    logic [5:0]  opc;
    logic [4:0]  rd;
    logic        stall;
  } exp_t;

  exp_t expq[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic sampled_reset;

  function automatic logic [31:0] ref_alu(input logic [31:0] pc, rs1, rs2, imm,
                                          input logic [5:0] opc, input logic f7);
    logic [2:0]  cls = opc[5:3];
    logic [2:0]  f3  = opc[2:0];
    logic [31:0] b   = (cls == 3'd2) ? rs2 : imm;
    int          sh  = int'(b[4:0]);
    case (cls)
      3'd0, 3'd1: return rs1 + imm;
      3'd2, 3'd3: begin
        case (f3)
          3'd0: return (cls == 3'd2 && f7) ? rs1 - b : rs1 + b;
          3'd1: return rs1 << sh;
          3'd2: return ($signed(rs1) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: return (rs1 < b) ? 32'd1 : 32'd0;
          3'd4: return rs1 ^ b;
          3'd5: return f7 ? 32'($signed(rs1) >>> sh) : rs1 >> sh;
          3'd6: return rs1 | b;
          default: return rs1 & b;
        endcase
      end
      3'd4: return imm;
      3'd5: return pc + imm;
      3'd6: return pc + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Every clock edge produces exactly one registered outcome, popped here.
  initial begin
    forever begin
      @(posedge clk);
      sampled_reset = reset;
      #1;
      if (sampled_reset) begin
        chk("reset alu_out", bus.alu_out_o, 32'd0);
        chk("reset dmem", bus.dmem_data_o, 32'd0);
        chk("reset opcode", 32'(bus.opcode_o), 32'd0);
        chk("reset rd", 32'(bus.rd_o), 32'd0);
        chk("reset stall", 32'(bus.stall_o), 32'd0);
        expq.delete();
      end else if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL model queue underflow at t=%0t", $time);
      end else begin
        e = expq.pop_front();
        chk("alu_out", bus.alu_out_o, e.alu);
        chk("dmem_data", bus.dmem_data_o, e.dmem);
        chk("opcode", 32'(bus.opcode_o), 32'(e.opc));
        chk("rd", 32'(bus.rd_o), 32'(e.rd));
        chk("stall", 32'(bus.stall_o), 32'(e.stall));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic set_idle();
    bus.pc_i = 32'd0; bus.rs1_data_i = 32'd0; bus.rs2_data_i = 32'd0; bus.imm_i = 32'd0;
    bus.opcode_i = 6'd0; bus.funct7b_i = 1'b0; bus.rd_i = 5'd0; bus.stall_i = 1'b1;
  endtask

  // Called at a negedge; presents one instruction and holds it for its full
  // duration (or hold_limit cycles if nonzero), returning at a negedge.
  task automatic issue(input logic [31:0] pc, rs1, rs2, imm, input logic [5:0] opc,
                       input logic f7, input logic [4:0] rd, input logic st,
                       input int hold_limit);
    logic [2:0] cls = opc[5:3];
    logic       shift_op;
    int         n, len, hold;
    exp_t       b, r;
    bus.pc_i = pc; bus.rs1_data_i = rs1; bus.rs2_data_i = rs2; bus.imm_i = imm;
    bus.opcode_i = opc; bus.funct7b_i = f7; bus.rd_i = rd; bus.stall_i = st;
    shift_op = (cls == 3'd2 || cls == 3'd3) && (opc[2:0] == 3'd1 || opc[2:0] == 3'd5);
    n   = int'(((cls == 3'd2) ? rs2[4:0] : imm[4:0]));
    len = (SERIAL && shift_op && n != 0 && !st) ? n + 1 : 1;
    b = '{alu: 32'd0, dmem: 32'd0, opc: 6'd0, rd: 5'd0, stall: 1'b1};
    r = '{alu: ref_alu(pc, rs1, rs2, imm, opc, f7), dmem: rs2, opc: opc, rd: rd, stall: 1'b0};
    if (st) expq.push_back(b);
    else begin
      for (int k = 0; k < len - 1; k++) expq.push_back(b);
      expq.push_back(r);
    end
    hold = (hold_limit > 0 && hold_limit < len) ? hold_limit : len;
    for (int k = 0; k < hold; k++) begin
      #1;
      chk("busy", 32'(bus.busy_o), (k < len - 1) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    set_idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    issue(32'h0, 32'd5, 32'd7, 32'd0, 6'b010_000, 1'b0, 5'd1, 1'b0, 0);
    chk("ADD 5+7", bus.alu_out_o, 32'd12);
    chk("ADD stall_o", 32'(bus.stall_o), 32'd0);
    issue(32'h0, 32'd3, 32'd5, 32'd0, 6'b010_000, 1'b1, 5'd2, 1'b0, 0);
    chk("SUB 3-5", bus.alu_out_o, 32'hFFFF_FFFE);
    issue(32'h0, 32'd1, 32'hFFFF_FFFF, 32'd0, 6'b010_011, 1'b0, 5'd3, 1'b0, 0);
    chk("SLTU", bus.alu_out_o, 32'd1);
    issue(32'h0, 32'd1, 32'hFFFF_FFFF, 32'd0, 6'b010_010, 1'b0, 5'd4, 1'b0, 0);
    chk("SLT", bus.alu_out_o, 32'd0);
    issue(32'h0, 32'h100, 32'hDEAD_BEEF, 32'h8, 6'b001_010, 1'b0, 5'd0, 1'b0, 0);
    chk("store addr", bus.alu_out_o, 32'h108);
    chk("store data", bus.dmem_data_o, 32'hDEAD_BEEF);
    issue(32'h0, 32'h8000_0000, 32'd0, 32'd4, 6'b011_101, 1'b1, 5'd5, 1'b0, 0);
    chk("SRA by 4", bus.alu_out_o, 32'hF800_0000);
    issue(32'h0, 32'h8000_0000, 32'd0, 32'd0, 6'b011_101, 1'b1, 5'd6, 1'b0, 0);
    chk("SRA by 0", bus.alu_out_o, 32'h8000_0000);
    issue(32'h0, 32'h1234_5678, 32'd9, 32'd3, 6'b011_001, 1'b0, 5'd7, 1'b1, 0);
    chk("stalled SLL stall_o", 32'(bus.stall_o), 32'd1);
    chk("stalled SLL alu_out", bus.alu_out_o, 32'd0);
    issue(32'h0, 32'hF0, 32'd0, 32'd4, 6'b011_101, 1'b0, 5'd8, 1'b0, 0);
    chk("SRL F0>>4", bus.alu_out_o, 32'h0F);
    issue(32'h4000, 32'd0, 32'd0, 32'h10, 6'b110_000, 1'b0, 5'd9, 1'b0, 0);
    chk("JAL link", bus.alu_out_o, 32'h4004);

    // Abort a long shift with reset partway through.
    issue(32'h0, 32'd1, 32'd0, 32'd31, 6'b011_001, 1'b0, 5'd10, 1'b0, 10);
    reset = 1'b1;
    set_idle();
    @(negedge clk);
    chk("busy after reset", 32'(bus.busy_o), 32'd0);
    chk("alu_out after reset", bus.alu_out_o, 32'd0);
    reset = 1'b0;
    issue(32'h0, 32'd1, 32'd2, 32'd0, 6'b010_000, 1'b0, 5'd11, 1'b0, 0);
    chk("ADD after abort", bus.alu_out_o, 32'd3);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] imm;
      imm = $urandom;
      if ($urandom_range(0, 1) == 1) imm = 32'($urandom_range(0, 31));
      issue($urandom, $urandom, $urandom, imm, 6'($urandom_range(0, 63)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 7) == 0), 0);
    end

    chk("model queue drained", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
